fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end of the pipelined MIPS core. It owns the PC, issues in-order requests to an instruction-memory port over a valid/ready handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode consumes the queue over a valid/ready handshake. A redirect from branch or jump resolution flushes the queue and discards in-flight responses. This block replaces the fixed PC+IM+F/D-register arrangement and keeps fetching while decode stalls.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue_unit_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_queue_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// FETCH_ALIGN_CHK_EN adds the misaligned-PC fault bit to each queue entry.
package fetch_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
`ifdef FETCH_ALIGN_CHK_EN
        logic                    exc;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory and decode handshakes of the fetch front end.
// FETCH_ALIGN_CHK_EN adds d_exc to the decode side.
interface fetch_queue_unit_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            d_valid;
    logic            d_ready;
    logic [XLEN-1:0] d_instr;
    logic [XLEN-1:0] d_pc;
`ifdef FETCH_ALIGN_CHK_EN
    logic            d_exc;
`endif

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output d_valid, d_instr, d_pc,
`ifdef FETCH_ALIGN_CHK_EN
        output d_exc,
`endif
        input  d_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  d_valid, d_instr, d_pc,
`ifdef FETCH_ALIGN_CHK_EN
        input  d_exc,
`endif
        output d_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. Push while full is accepted only with a pop.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, issues in-order imem requests under a credit
// limit and queues {pc, instr} for decode. FETCH_ALIGN_CHK_EN enables the
// misaligned-PC fault entry; otherwise redirect targets are word-aligned.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    fetch_queue_unit_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef FETCH_ALIGN_CHK_EN
        logic            exc;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] occ, inflight;
    logic [CNT_W:0]   credit_used;
    logic             has_credit;
    logic             issue_en;
    logic             req_fire;
    logic             q_push, q_pop, q_full, q_empty;
    entry_t           q_din, q_head;
    logic [XLEN-1:0]  addr_head;
    logic             addr_full, addr_empty;
    logic [XLEN-1:0]  redirect_tgt;
    logic             unused_ok;

    // Outstanding requests reserve queue slots, so a response always fits.
    assign credit_used = {1'b0, occ} + {1'b0, inflight};
    assign has_credit  = (credit_used < (CNT_W+1)'(DEPTH));

`ifdef FETCH_ALIGN_CHK_EN
    logic exc_done_q, exc_done_d;
    logic pc_aligned;

    assign pc_aligned   = (pc_q[1:0] == 2'b00);
    assign redirect_tgt = redirect_pc;
    assign issue_en     = !reset && !redirect_valid && has_credit && pc_aligned;
    assign unused_ok    = &{1'b0, q_full, addr_full, addr_empty};
`else
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign issue_en     = !reset && !redirect_valid && has_credit;
    assign unused_ok    = &{1'b0, q_full, addr_full, addr_empty, redirect_pc[1:0]};
`endif

    assign req_fire = issue_en && bus.imem_req_ready;
    assign q_pop    = !q_empty && bus.d_ready && !redirect_valid;

    always_comb begin
        pc_d        = pc_q;
        drop_d      = drop_q;
        q_push      = 1'b0;
        q_din.pc    = addr_head;
        q_din.instr = bus.imem_rsp_data;
`ifdef FETCH_ALIGN_CHK_EN
        q_din.exc   = 1'b0;
        exc_done_d  = exc_done_q;
`endif
        if (redirect_valid) begin
            pc_d   = redirect_tgt;
            // Every request still outstanding after this edge is stale; any
            // already marked for dropping is included in inflight.
            drop_d = inflight - CNT_W'(bus.imem_rsp_valid);
`ifdef FETCH_ALIGN_CHK_EN
            exc_done_d = 1'b0;
`endif
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (bus.imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    q_push = 1'b1;
                end
            end
`ifdef FETCH_ALIGN_CHK_EN
            if (!pc_aligned && !exc_done_q && has_credit && !q_push) begin
                q_push      = 1'b1;
                q_din.pc    = pc_q;
                q_din.instr = XLEN'(NOP);
                q_din.exc   = 1'b1;
                exc_done_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_done_q <= 1'b0;
        end else begin
            exc_done_q <= exc_done_d;
        end
    end
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_head),
        .count (occ),
        .full  (q_full),
        .empty (q_empty)
    );

    // Address FIFO tracks issued PCs in order; it is never flushed so that
    // it stays aligned with responses still owed by the memory.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (req_fire),
        .pop   (bus.imem_rsp_valid),
        .din   (pc_q),
        .dout  (addr_head),
        .count (inflight),
        .full  (addr_full),
        .empty (addr_empty)
    );

    assign bus.imem_req_valid = issue_en;
    assign bus.imem_req_addr  = pc_q;
    assign bus.d_valid        = !q_empty;
    assign bus.d_instr        = q_empty ? XLEN'(NOP) : q_head.instr;
    assign bus.d_pc           = q_empty ? '0 : q_head.pc;
`ifdef FETCH_ALIGN_CHK_EN
    assign bus.d_exc          = !q_empty && q_head.exc;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a 1-cycle in-order memory model.
// Build with FETCH_ALIGN_CHK_EN to include the misaligned-redirect vectors.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_queue_unit_if #(.XLEN(32)) bus ();

    fetch_queue_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          acc_cnt = 0;
    int          acc_base;
    int          n;
    int          exp_drop;
    logic        mem_en;
    logic [31:0] pend [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic drive_rsp();
        bus.imem_rsp_valid = mem_en && (pend.size() > 0);
        bus.imem_rsp_data  = (pend.size() > 0) ? instr_of(pend[0]) : 32'h0;
    endtask

    // One clock: sample handshakes mid-cycle, advance the memory model at
    // the edge, then present the next response at the falling edge.
    task automatic step();
        logic        fire, rsp, rst;
        logic [31:0] addr;
        #1;
        fire = bus.imem_req_valid && bus.imem_req_ready;
        addr = bus.imem_req_addr;
        rsp  = bus.imem_rsp_valid;
        rst  = reset;
        @(posedge clk);
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp) void'(pend.pop_front());
            if (fire) begin
                pend.push_back(addr);
                acc_cnt++;
            end
        end
        @(negedge clk);
        drive_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset              = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        mem_en             = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.d_ready        = 1'b0;

        // Reset values
        @(negedge clk);
        drive_rsp();
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_d_valid",   bus.d_valid, 0);
        chk("rst_d_instr",   bus.d_instr, 0);
        chk("rst_d_pc",      bus.d_pc, 0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("rst_d_exc",     bus.d_exc, 0);
`endif
        step();

        // Back-to-back issue and first-response latency
        reset = 1'b0;
        #1;
        chk("t1_req_valid", bus.imem_req_valid, 1);
        chk("t1_addr0", bus.imem_req_addr, 32'h3000);
        step();
        chk("t1_addr1", bus.imem_req_addr, 32'h3004);
        chk("t1_dvalid_early", bus.d_valid, 0);
        step();
        chk("t1_dvalid", bus.d_valid, 1);
        chk("t1_d_pc", bus.d_pc, 32'h3000);
        chk("t1_d_instr", bus.d_instr, 32'hDEAD_3000);
        chk("t1_addr2", bus.imem_req_addr, 32'h3008);

        // Decode stalled: credit limit stops issue at DEPTH
        repeat (6) step();
        chk("t2_acc_full", acc_cnt, 4);
        chk("t2_req_stop", bus.imem_req_valid, 0);
        chk("t2_head_pc", bus.d_pc, 32'h3000);
        bus.d_ready = 1'b1;
        #1;
        chk("t2_req_stop_pop", bus.imem_req_valid, 0);
        step();
        bus.d_ready = 1'b0;
        #1;
        chk("t2_req_reopen", bus.imem_req_valid, 1);
        chk("t2_addr_next", bus.imem_req_addr, 32'h3010);
        chk("t2_head_after_pop", bus.d_pc, 32'h3004);
        step();
        chk("t2_req_stop2", bus.imem_req_valid, 0);
        repeat (3) step();
        chk("t2_acc_one_more", acc_cnt, 5);
        chk("t2_req_stop3", bus.imem_req_valid, 0);

        // Reset mid-operation, then redirect with 3 requests in flight
        reset = 1'b1;
        step();
        reset       = 1'b0;
        mem_en      = 1'b0;
        bus.d_ready = 1'b1;
        drive_rsp();
        #1;
        chk("t3_rst_dvalid", bus.d_valid, 0);
        chk("t3_rst_addr", bus.imem_req_addr, 32'h3000);
        repeat (3) step();
        chk("t3_addr_before", bus.imem_req_addr, 32'h300C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3400;
        #1;
        chk("t3_redir_blocks_req", bus.imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        mem_en         = 1'b1;
        drive_rsp();
        #1;
        chk("t3_dvalid_after", bus.d_valid, 0);
        chk("t3_req_valid", bus.imem_req_valid, 1);
        chk("t3_addr_redir", bus.imem_req_addr, 32'h3400);
        chk("t3_drop", dut.drop_q, 3);
        n = 0;
        while (!bus.d_valid && n < 10) begin
            step();
            n++;
        end
        chk("t3_latency", n, 4);
        chk("t3_d_pc", bus.d_pc, 32'h3400);
        chk("t3_d_instr", bus.d_instr, 32'hDEAD_3400);

        // Redirect coinciding with a response and a pop
        chk("t4_pop_pending", bus.d_valid && bus.d_ready, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3600;
        #1;
        exp_drop = pend.size() - (bus.imem_rsp_valid ? 1 : 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t4_drop", dut.drop_q, exp_drop);
        chk("t4_dvalid_after", bus.d_valid, 0);
        chk("t4_addr_redir", bus.imem_req_addr, 32'h3600);
        n = 0;
        while (!bus.d_valid && n < 10) begin
            step();
            n++;
        end
        chk("t4_latency", n, 3);
        chk("t4_d_pc", bus.d_pc, 32'h3600);
        chk("t4_d_instr", bus.d_instr, 32'hDEAD_3600);

        // Memory not ready: held request keeps its address
        reset              = 1'b1;
        bus.imem_req_ready = 1'b0;
        step();
        reset       = 1'b0;
        bus.d_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_addr", bus.imem_req_addr, 32'h3000);
            step();
        end
        chk("t5_hold_valid", bus.imem_req_valid, 1);
        bus.imem_req_ready = 1'b1;
        #1;
        chk("t5_addr_at_accept", bus.imem_req_addr, 32'h3000);
        step();
        chk("t5_addr_advance", bus.imem_req_addr, 32'h3004);

`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned redirect yields one fault entry and halts issue
        reset = 1'b1;
        step();
        reset          = 1'b0;
        bus.d_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3402;
        acc_base       = acc_cnt;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("ac_no_req", bus.imem_req_valid, 0);
        chk("ac_dvalid_early", bus.d_valid, 0);
        step();
        chk("ac_dvalid", bus.d_valid, 1);
        chk("ac_d_pc", bus.d_pc, 32'h3402);
        chk("ac_d_instr", bus.d_instr, 32'h0);
        chk("ac_d_exc", bus.d_exc, 1);
        chk("ac_no_req2", bus.imem_req_valid, 0);
        bus.d_ready = 1'b1;
        step();
        bus.d_ready = 1'b0;
        repeat (3) step();
        chk("ac_single_entry", bus.d_valid, 0);
        chk("ac_no_accepts", acc_cnt, acc_base);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3500;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("ac_resume_valid", bus.imem_req_valid, 1);
        chk("ac_resume_addr", bus.imem_req_addr, 32'h3500);
        chk("ac_exc_clear", bus.d_exc, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
